// File: rtl/segment_master.sv
// Avalon-MM master that sweeps eight encoded hex digits plus a blink mask into the
// seven-segment display slave. Optional SEGMENT_MASTER_DIFF_EN skips unchanged registers.
module segment_master #(
    parameter int unsigned REFRESH_DIV = 5000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] digits_in,
    input  logic [7:0]  dp_in,
    input  logic [7:0]  blink_in,
    input  logic        update,
    output logic        busy,
    output logic        done,
    output logic [3:0]  master_address,
    output logic        master_write,
    output logic [7:0]  master_writedata,
    input  logic        master_waitrequest,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {IDLE, SNAP, WRITE, DONE} state_t;

    // Handshake: a write completes on a cycle with master_write=1 and
    // master_waitrequest=0; until then address, data and write stay unchanged.

    state_t      state_q, state_n;
    logic [3:0]  index_q, index_n;
    logic        pending_q, pending_n;
    logic [31:0] refresh_cnt;
    logic        expiry;
    logic        trig;
    logic        accept;
    logic [31:0] shadow_digits;
    logic [7:0]  shadow_dp;
    logic [7:0]  shadow_blink;
    logic [7:0]  vals [0:8];
    logic [8:0]  dirty;
    logic [3:0]  start;
    logic [3:0]  nxt;
    logic        busy_n, done_n, write_n;
    logic [3:0]  addr_n;
    logic [7:0]  data_n;
`ifdef SEGMENT_MASTER_DIFF_EN
    logic [7:0]  cache [0:8];
    logic [8:0]  cache_valid;
`endif

    function automatic logic [7:0] enc(input logic [3:0] nib, input logic dp);
        logic [7:0] seg;
        seg = 8'hFF;
        case (nib)
            4'h0: seg = 8'hC0;
            4'h1: seg = 8'hF9;
            4'h2: seg = 8'hA4;
            4'h3: seg = 8'hB0;
            4'h4: seg = 8'h99;
            4'h5: seg = 8'h92;
            4'h6: seg = 8'h82;
            4'h7: seg = 8'hF8;
            4'h8: seg = 8'h80;
            4'h9: seg = 8'h90;
            4'hA: seg = 8'h88;
            4'hB: seg = 8'h83;
            4'hC: seg = 8'hC6;
            4'hD: seg = 8'hA1;
            4'hE: seg = 8'h86;
            4'hF: seg = 8'h8E;
            default: seg = 8'hFF;
        endcase
        if (dp) seg[7] = 1'b0;
        return seg;
    endfunction

    assign state_dbg = state_q;
    assign expiry    = (REFRESH_DIV != 0) && (refresh_cnt == REFRESH_DIV - 1);
    assign trig      = update || expiry;
    assign accept    = master_write && !master_waitrequest;

    // During SNAP the shadows are not yet loaded, so the first write is encoded from the inputs.
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            vals[k] = (state_q == SNAP) ? enc(digits_in[4*k +: 4], dp_in[k])
                                        : enc(shadow_digits[4*k +: 4], shadow_dp[k]);
        end
        vals[8] = (state_q == SNAP) ? blink_in : shadow_blink;
    end

    always_comb begin
        for (int k = 0; k < 9; k++) begin
`ifdef SEGMENT_MASTER_DIFF_EN
            dirty[k] = !cache_valid[k] || (cache[k] != vals[k]);
`else
            dirty[k] = 1'b1;
`endif
        end
    end

    // Lowest register at or after start that still needs writing; 9 means none left.
    always_comb begin
        start = (state_q == SNAP) ? 4'd0 : index_q + 4'd1;
        nxt   = 4'd9;
        for (int k = 8; k >= 0; k--) begin
            if (4'(k) >= start && dirty[k]) nxt = 4'(k);
        end
    end

    always_comb begin
        state_n   = state_q;
        index_n   = index_q;
        pending_n = pending_q;
        done_n    = 1'b0;
        write_n   = master_write;
        addr_n    = master_address;
        data_n    = master_writedata;
        case (state_q)
            IDLE: begin
                if (trig || pending_q) begin
                    state_n   = SNAP;
                    pending_n = 1'b0;
                end
            end
            SNAP: begin
                if (trig) pending_n = 1'b1;
                if (nxt == 4'd9) begin
                    state_n = DONE;
                    done_n  = 1'b1;
                    write_n = 1'b0;
                    addr_n  = 4'd0;
                    data_n  = 8'hFF;
                end else begin
                    state_n = WRITE;
                    index_n = nxt;
                    write_n = 1'b1;
                    addr_n  = nxt;
                    data_n  = vals[nxt];
                end
            end
            WRITE: begin
                if (trig) pending_n = 1'b1;
                if (accept) begin
                    if (nxt == 4'd9) begin
                        state_n = DONE;
                        done_n  = 1'b1;
                        write_n = 1'b0;
                        addr_n  = 4'd0;
                        data_n  = 8'hFF;
                    end else begin
                        index_n = nxt;
                        addr_n  = nxt;
                        data_n  = vals[nxt];
                    end
                end
            end
            DONE: begin
                if (trig || pending_q) begin
                    state_n   = SNAP;
                    pending_n = 1'b0;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q          <= IDLE;
            index_q          <= 4'd0;
            pending_q        <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            master_write     <= 1'b0;
            master_address   <= 4'd0;
            master_writedata <= 8'hFF;
            shadow_digits    <= 32'd0;
            shadow_dp        <= 8'd0;
            shadow_blink     <= 8'd0;
        end else begin
            state_q          <= state_n;
            index_q          <= index_n;
            pending_q        <= pending_n;
            busy             <= busy_n;
            done             <= done_n;
            master_write     <= write_n;
            master_address   <= addr_n;
            master_writedata <= data_n;
            if (state_q == SNAP) begin
                shadow_digits <= digits_in;
                shadow_dp     <= dp_in;
                shadow_blink  <= blink_in;
            end
        end
    end

`ifdef SEGMENT_MASTER_DIFF_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            cache_valid <= 9'd0;
            for (int k = 0; k < 9; k++) cache[k] <= 8'd0;
        end else if (accept) begin
            cache[master_address]       <= master_writedata;
            cache_valid[master_address] <= 1'b1;
        end
    end
`endif

    // Free-running refresh timer; it keeps counting through sweeps.
    always_ff @(posedge clk) begin
        if (!reset) begin
            refresh_cnt <= 32'd0;
        end else if (REFRESH_DIV == 0 || expiry) begin
            refresh_cnt <= 32'd0;
        end else begin
            refresh_cnt <= refresh_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_segment_master.sv
// Bench for segment_master: directed sweeps plus a randomized run against a
// transaction-level model of the display sweep.
module tb_segment_master;

    localparam int unsigned DIV = 300;

    logic        clk;
    logic        rst_n;
    logic [31:0] digits_in;
    logic [7:0]  dp_in;
    logic [7:0]  blink_in;
    logic        update;
    logic        busy;
    logic        done;
    logic [3:0]  master_address;
    logic        master_write;
    logic [7:0]  master_writedata;
    logic        waitrequest;
    logic [1:0]  state_dbg;

    segment_master #(.REFRESH_DIV(DIV)) dut (
        .clk               (clk),
        .reset             (rst_n),
        .digits_in         (digits_in),
        .dp_in             (dp_in),
        .blink_in          (blink_in),
        .update            (update),
        .busy              (busy),
        .done              (done),
        .master_address    (master_address),
        .master_write      (master_write),
        .master_writedata  (master_writedata),
        .master_waitrequest(waitrequest),
        .state_dbg         (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    logic [7:0] basic_exp [9] = '{8'h00, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E, 8'hA5};

    // Reference model: sweep phase, pending request, refresh count and the expected write list.
    int          m_phase;
    bit          m_pend;
    int unsigned m_cnt;
    logic [11:0] exp_q[$];
    logic [7:0]  m_cache [9];
    bit          m_cv [9];

    int         obs_a[$];
    int         obs_d[$];
    int         obs_c[$];
    int         done_c[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [7:0] seg_of(input logic [3:0] n, input logic dp);
        return dp ? (seg_tab[n] & 8'h7F) : seg_tab[n];
    endfunction

    task automatic model_step();
        bit trig;
        logic [7:0] d;
        logic [11:0] e;
        if (!rst_n) begin
            m_phase = 0;
            m_pend  = 0;
            m_cnt   = 0;
            exp_q.delete();
            for (int i = 0; i < 9; i++) m_cv[i] = 0;
            return;
        end
        trig  = update || (DIV != 0 && m_cnt == DIV - 1);
        m_cnt = (DIV == 0) ? 0 : (m_cnt + 1) % DIV;
        case (m_phase)
            0: if (trig || m_pend) begin m_phase = 1; m_pend = 0; end
            1: begin
                if (trig) m_pend = 1;
                exp_q.delete();
                for (int i = 0; i < 9; i++) begin
                    d = (i < 8) ? seg_of(digits_in[4*i +: 4], dp_in[i]) : blink_in;
`ifdef SEGMENT_MASTER_DIFF_EN
                    if (m_cv[i] && m_cache[i] == d) continue;
`endif
                    exp_q.push_back({4'(i), d});
                end
                m_phase = (exp_q.size() == 0) ? 3 : 2;
            end
            2: begin
                if (trig) m_pend = 1;
                if (!waitrequest) begin
                    e = exp_q.pop_front();
                    m_cache[e[11:8]] = e[7:0];
                    m_cv[e[11:8]]    = 1;
                    if (exp_q.size() == 0) m_phase = 3;
                end
            end
            default: begin
                if (trig || m_pend) begin m_phase = 1; m_pend = 0; end
                else m_phase = 0;
            end
        endcase
    endtask

    task automatic compare_out();
        bit wr;
        wr = (m_phase == 2) && (exp_q.size() > 0);
        check("busy", busy, m_phase != 0);
        check("done", done, m_phase == 3);
        check("write", master_write, wr);
        check("addr", master_address, wr ? exp_q[0][11:8] : 4'd0);
        check("data", master_writedata, wr ? exp_q[0][7:0] : 8'hFF);
    endtask

    task automatic record_obs();
        if (rst_n === 1'b1 && master_write === 1'b1 && waitrequest == 1'b0) begin
            obs_a.push_back(int'(master_address));
            obs_d.push_back(int'(master_writedata));
            obs_c.push_back(cyc);
        end
        if (rst_n === 1'b1 && done === 1'b1) done_c.push_back(cyc);
    endtask

    task automatic cycle();
        record_obs();
        model_step();
        @(negedge clk);
        cyc++;
        compare_out();
    endtask

    task automatic clear_obs();
        obs_a.delete();
        obs_d.delete();
        obs_c.delete();
        done_c.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        update = 1'b0;
        waitrequest = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
        cycle();
    endtask

    task automatic basic_sweep();
        int t;
        do_reset();
        digits_in = 32'hFEDCBA98;
        dp_in = 8'h01;
        blink_in = 8'hA5;
        clear_obs();
        t = cyc;
        update = 1'b1;
        cycle();
        update = 1'b0;
        repeat (12) cycle();
        check("basic_nwr", obs_a.size(), 9);
        for (int i = 0; i < obs_a.size() && i < 9; i++) begin
            check("basic_addr", obs_a[i], i);
            check("basic_data", obs_d[i], basic_exp[i]);
            check("basic_cyc", obs_c[i], t + 2 + i);
        end
        check("basic_ndone", done_c.size(), 1);
        if (done_c.size() > 0) check("basic_done_cyc", done_c[0], t + 11);
    endtask

    initial begin
        int t;
        int last_wr [9];
        logic [31:0] dig_c;
        rst_n = 1'b0;
        digits_in = '0;
        dp_in = '0;
        blink_in = '0;
        update = 1'b0;
        waitrequest = 1'b0;

        // reset held with update asserted
        update = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_write", master_write, 0);
            check("rst_addr", master_address, 0);
            check("rst_data", master_writedata, 8'hFF);
        end

        basic_sweep();

`ifdef SEGMENT_MASTER_DIFF_EN
        digits_in = 32'hFEDC0A98;
        clear_obs();
        t = cyc;
        update = 1'b1;
        cycle();
        update = 1'b0;
        repeat (6) cycle();
        check("diff_nwr", obs_a.size(), 1);
        if (obs_a.size() > 0) begin
            check("diff_addr", obs_a[0], 3);
            check("diff_data", obs_d[0], 8'hC0);
        end
        check("diff_ndone", done_c.size(), 1);
        if (done_c.size() > 0) check("diff_done_cyc", done_c[0], t + 3);
        clear_obs();
        t = cyc;
        update = 1'b1;
        cycle();
        update = 1'b0;
        repeat (6) cycle();
        check("diff_nowr", obs_a.size(), 0);
        check("diff_ndone2", done_c.size(), 1);
        if (done_c.size() > 0) check("diff_done_cyc2", done_c[0], t + 2);
`endif

        // stall on address 4
        do_reset();
        digits_in = 32'hFEDCBA98;
        dp_in = 8'h01;
        blink_in = 8'hA5;
        clear_obs();
        t = cyc;
        update = 1'b1;
        cycle();
        update = 1'b0;
        for (int k = 0; k < 15; k++) begin
            waitrequest = (cyc >= t + 6 && cyc <= t + 8);
            cycle();
            if (cyc >= t + 6 && cyc <= t + 9) begin
                check("stall_write", master_write, 1);
                check("stall_addr", master_address, 4);
                check("stall_data", master_writedata, 8'hC6);
            end
        end
        waitrequest = 1'b0;
        check("stall_nwr", obs_a.size(), 9);
        for (int i = 0; i < obs_a.size() && i < 9; i++) check("stall_addr_seq", obs_a[i], i);
        check("stall_ndone", done_c.size(), 1);
        if (done_c.size() > 0) check("stall_done_cyc", done_c[0], t + 14);

        // two requests during a sweep coalesce into one extra sweep
        do_reset();
        digits_in = $urandom;
        dp_in = 8'($urandom);
        blink_in = 8'h3C;
        dig_c = $urandom;
        clear_obs();
        t = cyc;
        update = 1'b1;
        cycle();
        for (int k = 0; k < 30; k++) begin
            update = 1'b0;
            if (cyc == t + 4) begin digits_in = $urandom; update = 1'b1; end
            if (cyc == t + 7) begin digits_in = dig_c; update = 1'b1; end
            cycle();
        end
        update = 1'b0;
        check("coal_ndone", done_c.size(), 2);
        if (done_c.size() > 0) check("coal_done0", done_c[0], t + 11);
        for (int i = 0; i < 9; i++) last_wr[i] = -1;
        for (int i = 0; i < obs_a.size(); i++) if (obs_a[i] < 9) last_wr[obs_a[i]] = obs_d[i];
        for (int i = 0; i < 8; i++) check("coal_last", last_wr[i], seg_of(dig_c[4*i +: 4], dp_in[i]));
        check("coal_blink", last_wr[8], 8'h3C);

        // reset during the write to address 5
        do_reset();
        clear_obs();
        t = cyc;
        update = 1'b1;
        cycle();
        update = 1'b0;
        while (cyc < t + 7) cycle();
        check("mid_addr5", master_address, 5);
        rst_n = 1'b0;
        cycle();
        check("mid_write", master_write, 0);
        check("mid_busy", busy, 0);
        rst_n = 1'b1;
        repeat (3) cycle();
        clear_obs();
        update = 1'b1;
        cycle();
        update = 1'b0;
        repeat (12) cycle();
        check("mid_nwr", obs_a.size(), 9);
        if (obs_a.size() > 0) check("mid_first_addr", obs_a[0], 0);

        // randomized run, including refresh expiries and occasional resets
        for (int k = 0; k < 3000; k++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            update = ($urandom_range(0, 9) == 0);
            waitrequest = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 19) == 0) digits_in[4*$urandom_range(0, 7) +: 4] = 4'($urandom);
            if ($urandom_range(0, 49) == 0) dp_in = 8'($urandom);
            if ($urandom_range(0, 49) == 0) blink_in = 8'($urandom);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
